mac_rx_ctrl: RTL and testbench

Sequencer for the MAC RX frame reader. It watches the RX FIFO fill level and starts one frame read at a time over the `fs`/`fd` handshake. It captures the 96-bit frame image, qualifies it against a tag and the MAC error flag, and hands good frames downstream on a valid/ready port. It sits between the RX FIFO status, the frame reader, and the frame consumer, and it counts dropped and timed-out frames.

---
 rtl/mac_rx_pkg.sv | 18 +
 rtl/mac_rx_wdog.sv | 28 ++
 rtl/mac_rx_ctrl.sv | 125 ++++++++++++
 tb/tb_mac_rx_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_rx_pkg.sv
// Shared constants and state encoding for the MAC RX frame-read sequencer.
package mac_rx_pkg;

  localparam int unsigned FRAME_BYTES_DEF = 12;
  localparam logic [15:0] MATCH_TAG_DEF   = 16'h55D5;
  localparam int unsigned FRM_W           = FRAME_BYTES_DEF * 8;
  localparam int unsigned ST_W            = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_REL   = 3'd2,
    ST_CHECK = 3'd3,
    ST_OUT   = 3'd4,
    ST_TMO   = 3'd5
  } state_e;

endpackage

// File: rtl/mac_rx_wdog.sv
// Read watchdog: counts cycles while run is high; expired flags the TIMEOUT-th cycle.
module mac_rx_wdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  assign expired = run && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mac_rx_ctrl.sv
// MAC RX frame-read sequencer: starts reads, qualifies captured frames, hands good ones downstream.
// Optional read timeout enabled by defining RX_CTRL_TIMEOUT_EN.
module mac_rx_ctrl
  import mac_rx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
  parameter logic [15:0] MATCH_TAG   = MATCH_TAG_DEF
`ifdef RX_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = 1023
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [11:0]                fifo_cnt,
  input  logic                       err,
  output logic                       fs,
  input  logic                       fd,
  input  logic [0:FRAME_BYTES*8-1]   rd_res,
  output logic [0:FRAME_BYTES*8-1]   frm_data,
  output logic                       frm_valid,
  input  logic                       frm_ready,
  output logic [15:0]                drop_cnt,
  output logic [7:0]                 tmo_cnt,
  output logic [2:0]                 state_rc
);

  state_e                     r_state;
  state_e                     w_nxt;
  logic                       r_bad;
  logic                       r_fs;
  logic                       r_valid;
  logic [0:FRAME_BYTES*8-1]   r_frm;
  logic [15:0]                r_drop;
  logic                       w_start;
  logic                       w_drop;

  assign w_start = en && (32'(fifo_cnt) >= FRAME_BYTES);
  assign w_drop  = r_bad || (r_frm[0:15] != MATCH_TAG);

`ifdef RX_CTRL_TIMEOUT_EN
  logic       w_expired;
  logic       w_wd_run;
  logic [7:0] r_tmo;

  assign w_wd_run = (r_state == ST_ARM);

  mac_rx_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!w_wd_run),
    .run     (w_wd_run),
    .expired (w_expired)
  );

  // One count per read abandoned by the watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= 8'd0;
    end else if ((r_state == ST_ARM) && (w_nxt == ST_TMO) && (r_tmo != 8'hFF)) begin
      r_tmo <= r_tmo + 8'd1;
    end
  end

  assign tmo_cnt = r_tmo;
`else
  assign tmo_cnt = 8'd0;
`endif

  // Next-state logic; fd takes priority over a coincident watchdog expiry
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_nxt = ST_ARM;
      ST_ARM:   if (fd) w_nxt = ST_REL;
`ifdef RX_CTRL_TIMEOUT_EN
                else if (w_expired) w_nxt = ST_TMO;
`endif
      ST_REL:   if (!fd) w_nxt = ST_CHECK;
      ST_CHECK: w_nxt = w_drop ? ST_IDLE : ST_OUT;
      ST_OUT:   if (frm_ready) w_nxt = ST_IDLE;
`ifdef RX_CTRL_TIMEOUT_EN
      ST_TMO:   if (!fd) w_nxt = ST_IDLE;
`endif
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_fs    <= 1'b0;
      r_valid <= 1'b0;
      r_bad   <= 1'b0;
      r_frm   <= '0;
      r_drop  <= 16'd0;
    end else begin
      r_state <= w_nxt;
      r_fs    <= (w_nxt == ST_ARM);
      r_valid <= (w_nxt == ST_OUT);
      // ARM is only entered from IDLE, so clearing in IDLE clears on ARM entry
      if (r_state == ST_IDLE) begin
        r_bad <= 1'b0;
      end else if ((r_state == ST_ARM) || (r_state == ST_REL)) begin
        r_bad <= r_bad | err;
      end
      if ((r_state == ST_ARM) && fd) begin
        r_frm <= rd_res;
      end
      if ((r_state == ST_CHECK) && w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign fs        = r_fs;
  assign frm_valid = r_valid;
  assign frm_data  = r_frm;
  assign drop_cnt  = r_drop;
  assign state_rc  = r_state;

endmodule

// File: tb/tb_mac_rx_ctrl.sv
// Directed self-checking bench for mac_rx_ctrl (RX_CTRL_TIMEOUT_EN selects the timeout scenario).
module tb_mac_rx_ctrl;
  import mac_rx_pkg::*;

  logic             clk;
  logic             rst;
  logic             en;
  logic [11:0]      fifo_cnt;
  logic             err;
  logic             fs;
  logic             fd;
  logic [0:FRM_W-1] rd_res;
  logic [0:FRM_W-1] frm_data;
  logic             frm_valid;
  logic             frm_ready;
  logic [15:0]      drop_cnt;
  logic [7:0]       tmo_cnt;
  logic [2:0]       state_rc;

  logic [0:FRM_W-1] exp_frm;
  int               n_chk;
  int               n_fail;

  mac_rx_ctrl #(
    .FRAME_BYTES (12),
    .MATCH_TAG   (16'h55D5)
`ifdef RX_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT     (8)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_cnt  (fifo_cnt),
    .err       (err),
    .fs        (fs),
    .fd        (fd),
    .rd_res    (rd_res),
    .frm_data  (frm_data),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .drop_cnt  (drop_cnt),
    .tmo_cnt   (tmo_cnt),
    .state_rc  (state_rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; fifo_cnt = 12'd0; err = 1'b0; fd = 1'b0;
    rd_res = '0; frm_ready = 1'b0; exp_frm = '0;
    step(); step();
    chk("rst_fs",    96'(fs),        96'(1'b0));
    chk("rst_valid", 96'(frm_valid), 96'(1'b0));
    chk("rst_data",  96'(frm_data),  96'(0));
    chk("rst_drop",  96'(drop_cnt),  96'(16'd0));
    chk("rst_tmo",   96'(tmo_cnt),   96'(8'd0));
    chk("rst_state", 96'(state_rc),  96'(3'd0));
    rst = 1'b0;
    step();
    chk("idle_no_en", 96'(state_rc), 96'(3'd0));

    // Good frame, fd returned 5 cycles after fs
    exp_frm = {16'h55D5, 80'h0123_4567_89AB_CDEF_0011};
    rd_res = exp_frm; en = 1'b1; fifo_cnt = 12'd12;
    step();
    chk("good_fs_rise", 96'(fs),       96'(1'b1));
    chk("good_arm",     96'(state_rc), 96'(3'd1));
    fifo_cnt = 12'd0;
    repeat (4) step();
    chk("good_fs_held", 96'(fs), 96'(1'b1));
    fd = 1'b1;
    step();
    chk("good_fs_fall", 96'(fs),       96'(1'b0));
    chk("good_rel",     96'(state_rc), 96'(3'd2));
    chk("good_capture", 96'(frm_data), 96'(exp_frm));
    fd = 1'b0; rd_res = ~exp_frm;
    step();
    chk("good_check",   96'(state_rc),  96'(3'd3));
    chk("good_nv_chk",  96'(frm_valid), 96'(1'b0));
    step();
    chk("good_valid",   96'(frm_valid), 96'(1'b1));
    chk("good_out",     96'(state_rc),  96'(3'd4));
    chk("good_data",    96'(frm_data),  96'(exp_frm));
    chk("good_drop",    96'(drop_cnt),  96'(16'd0));
    frm_ready = 1'b1;
    step();
    chk("good_acc_v",   96'(frm_valid), 96'(1'b0));
    chk("good_acc_st",  96'(state_rc),  96'(3'd0));
    frm_ready = 1'b0;

    // Tag mismatch
    rd_res = {16'h1234, 80'h0};
    fifo_cnt = 12'd12;
    step();
    fifo_cnt = 12'd0;
    step();
    fd = 1'b1;
    step();
    fd = 1'b0;
    step();
    chk("tag_check",   96'(state_rc),  96'(3'd3));
    chk("tag_nv",      96'(frm_valid), 96'(1'b0));
    step();
    chk("tag_idle",    96'(state_rc),  96'(3'd0));
    chk("tag_nv2",     96'(frm_valid), 96'(1'b0));
    chk("tag_drop",    96'(drop_cnt),  96'(16'd1));

    // Error in ARM
    rd_res = exp_frm;
    fifo_cnt = 12'd12;
    step();
    fifo_cnt = 12'd0; err = 1'b1;
    step();
    err = 1'b0; fd = 1'b1;
    step();
    fd = 1'b0;
    step();
    step();
    chk("err_arm_idle", 96'(state_rc), 96'(3'd0));
    chk("err_arm_drop", 96'(drop_cnt), 96'(16'd2));

    // Error in REL
    fifo_cnt = 12'd12;
    step();
    fifo_cnt = 12'd0; fd = 1'b1;
    step();
    err = 1'b1;
    step();
    err = 1'b0; fd = 1'b0;
    step();
    chk("err_rel_nv",   96'(frm_valid), 96'(1'b0));
    step();
    chk("err_rel_drop", 96'(drop_cnt),  96'(16'd3));

    // Error coincident with fd
    fifo_cnt = 12'd12;
    step();
    fifo_cnt = 12'd0; fd = 1'b1; err = 1'b1;
    step();
    fd = 1'b0; err = 1'b0;
    step();
    step();
    chk("err_fd_idle",  96'(state_rc),  96'(3'd0));
    chk("err_fd_nv",    96'(frm_valid), 96'(1'b0));
    chk("err_fd_drop",  96'(drop_cnt),  96'(16'd4));

    // Backpressure with a deep FIFO
    exp_frm = {16'h55D5, 80'hA5A5_5A5A_C3C3_3C3C_0FF0};
    rd_res = exp_frm; fifo_cnt = 12'd24;
    step();
    fd = 1'b1;
    step();
    step();
    fd = 1'b0; rd_res = '0;
    step();
    step();
    chk("bp_valid", 96'(frm_valid), 96'(1'b1));
    chk("bp_drop",  96'(drop_cnt),  96'(16'd4));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_v", 96'(frm_valid), 96'(1'b1));
      chk("bp_no_fs",  96'(fs),        96'(1'b0));
      chk("bp_data",   96'(frm_data),  96'(exp_frm));
    end
    frm_ready = 1'b1;
    step();
    chk("bp_acc_v",  96'(frm_valid), 96'(1'b0));
    chk("bp_acc_fs", 96'(fs),        96'(1'b0));
    chk("bp_acc_st", 96'(state_rc),  96'(3'd0));
    frm_ready = 1'b0;
    step();
    chk("bp_next_fs", 96'(fs),       96'(1'b1));
    chk("bp_next_st", 96'(state_rc), 96'(3'd1));
    en = 1'b0; fifo_cnt = 12'd0;

`ifdef RX_CTRL_TIMEOUT_EN
    // No fd: watchdog abandons the read after 8 ARM cycles
    repeat (7) step();
    chk("tmo_fs_held", 96'(fs),       96'(1'b1));
    step();
    chk("tmo_fs_fall", 96'(fs),       96'(1'b0));
    chk("tmo_state",   96'(state_rc), 96'(3'd5));
    chk("tmo_cnt1",    96'(tmo_cnt),  96'(8'd1));
    fd = 1'b1;
    step();
    chk("tmo_wait_fd", 96'(state_rc), 96'(3'd5));
    fd = 1'b0;
    step();
    chk("tmo_idle",    96'(state_rc), 96'(3'd0));
    chk("tmo_cnt_hold",96'(tmo_cnt),  96'(8'd1));
    chk("tmo_data",    96'(frm_data), 96'(exp_frm));
    en = 1'b1; fifo_cnt = 12'd12;
    step();
    chk("tmo_rearm",   96'(fs),       96'(1'b1));
`else
    // No fd and no watchdog: fs holds, en drop does not abort
    repeat (20) step();
    chk("nto_fs_held", 96'(fs),       96'(1'b1));
    chk("nto_state",   96'(state_rc), 96'(3'd1));
    chk("nto_tmo",     96'(tmo_cnt),  96'(8'd0));
`endif

    // Asynchronous reset in ARM
    #2 rst = 1'b1;
    #1;
    chk("arst_fs",    96'(fs),        96'(1'b0));
    chk("arst_state", 96'(state_rc),  96'(3'd0));
    chk("arst_valid", 96'(frm_valid), 96'(1'b0));
    chk("arst_drop",  96'(drop_cnt),  96'(16'd0));
    chk("arst_tmo",   96'(tmo_cnt),   96'(8'd0));
    chk("arst_data",  96'(frm_data),  96'(0));
    step(); step();
    rst = 1'b0;

    // fifo_cnt boundary: 11 must not start, 12 must
    en = 1'b1; fifo_cnt = 12'd11;
    repeat (5) step();
    chk("b11_fs",    96'(fs),       96'(1'b0));
    chk("b11_state", 96'(state_rc), 96'(3'd0));
    fifo_cnt = 12'd12;
    step();
    chk("b12_fs",    96'(fs),       96'(1'b1));
    chk("b12_state", 96'(state_rc), 96'(3'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
